// File: rtl/tt_bin_clock_btn.sv
// tt_bin_clock_btn
// Conditions the six raw time-set push buttons of the binary clock into
// clean single-cycle increment/decrement pulses for the hour, minute and
// seconds fields.
// Each button is synchronized, debounced and rise-detected. A pair whose
// two buttons are both held emits nothing.
//
// Optional feature macro: BTN_AUTOREPEAT_EN
//   defined   -> a held button (alone in its pair) auto-repeats.
//   undefined -> only press pulses are produced.
//
// Ports
//   clk_i        clock
//   rstn_i       synchronous active-low reset
//   btn_i[5:0]   raw buttons: [5] hour inc, [4] hour dec, [3] min inc,
//                [2] min dec, [1] sec inc, [0] sec dec
//   hour_id      [1] inc pulse, [0] dec pulse
//   minute_id    same encoding as hour_id
//   seconds_id   same encoding as hour_id
//   btn_state_o  debounced button levels, bit order as btn_i
module tt_bin_clock_btn #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int REPEAT_DELAY    = 65536,
  parameter int REPEAT_PERIOD   = 16384
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [5:0] btn_i,
  output logic [1:0] hour_id,
  output logic [1:0] minute_id,
  output logic [1:0] seconds_id,
  output logic [5:0] btn_state_o
);

  // Elaboration-time guard on the parameter ranges.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("tt_bin_clock_btn: all timing parameters must be >= 2");
  end

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);

  logic [5:0]     sync1_q, sync2_q;
  logic [5:0]     stable_q, stable_d;
  logic [5:0]     rise;
  logic [5:0]     press;
  logic [5:0]     pulse_d, pulse_q;
  logic [DBW-1:0] db_cnt_q [6];

  // Two-flop synchronizer on every raw button.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Next debounced level: a bit flips only once its synchronized value has
  // disagreed with the stable level for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 6; i++) begin
      if (sync2_q[i] != stable_q[i] && db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1))
        stable_d[i] = sync2_q[i];
    end
  end

  // Debounce counters count consecutive disagreeing edges and clear on
  // agreement or on the flip itself.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 6; i++) db_cnt_q[i] <= '0;
      stable_q <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (sync2_q[i] != stable_q[i] && stable_d[i] == stable_q[i])
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        else
          db_cnt_q[i] <= '0;
      end
      stable_q <= stable_d;
    end
  end

  assign rise = stable_d & ~stable_q;

  // A press only counts when its partner will not be held after this edge,
  // which also suppresses both when the pair rises together.
  always_comb begin
    press = '0;
    for (int p = 0; p < 3; p++) begin
      press[2*p+1] = rise[2*p+1] & ~stable_d[2*p];
      press[2*p]   = rise[2*p]   & ~stable_d[2*p+1];
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RCW = $clog2(REPEAT_DELAY + REPEAT_PERIOD) + 1;

  logic [RCW-1:0] rep_cnt_q [3];
  logic [2:0]     one_now, one_next, pair_rise, rep_due;
  logic [5:0]     rep_pulse;

  // The timer restarts whenever a pair enters the "exactly one held" state,
  // either by a press or by releasing one of two held buttons. After the
  // first repeat it parks at REPEAT_DELAY so later repeats are PERIOD apart.
  always_comb begin
    one_now   = '0;
    one_next  = '0;
    pair_rise = '0;
    rep_due   = '0;
    rep_pulse = '0;
    for (int p = 0; p < 3; p++) begin
      one_now[p]   = stable_q[2*p] ^ stable_q[2*p+1];
      one_next[p]  = stable_d[2*p] ^ stable_d[2*p+1];
      pair_rise[p] = rise[2*p] | rise[2*p+1];
      rep_due[p]   = (rep_cnt_q[p] == RCW'(REPEAT_DELAY - 1)) ||
                     (rep_cnt_q[p] == RCW'(REPEAT_DELAY + REPEAT_PERIOD - 1));
      if (one_now[p] && one_next[p] && !pair_rise[p] && rep_due[p]) begin
        rep_pulse[2*p+1] = stable_d[2*p+1];
        rep_pulse[2*p]   = stable_d[2*p];
      end
    end
    pulse_d = press | rep_pulse;
  end

  // Repeat timers, one per pair.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int p = 0; p < 3; p++) rep_cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (!one_now[p] || !one_next[p] || pair_rise[p])
          rep_cnt_q[p] <= '0;
        else if (rep_due[p])
          rep_cnt_q[p] <= RCW'(REPEAT_DELAY);
        else
          rep_cnt_q[p] <= rep_cnt_q[p] + 1'b1;
      end
    end
  end
`else
  assign pulse_d = press;
`endif

  // Registered command pulses.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) pulse_q <= '0;
    else         pulse_q <= pulse_d;
  end

  assign hour_id     = pulse_q[5:4];
  assign minute_id   = pulse_q[3:2];
  assign seconds_id  = pulse_q[1:0];
  assign btn_state_o = stable_q;

endmodule

// File: tb/tb_tt_bin_clock_btn.sv
// tb_tt_bin_clock_btn
// Self-checking bench for tt_bin_clock_btn with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8. Expectations follow BTN_AUTOREPEAT_EN.
module tb_tt_bin_clock_btn;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] btn;
  logic [1:0] hour_id, minute_id, seconds_id;
  logic [5:0] btn_state;

  always #5 clk = ~clk;

  tt_bin_clock_btn #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .btn_i      (btn),
    .hour_id    (hour_id),
    .minute_id  (minute_id),
    .seconds_id (seconds_id),
    .btn_state_o(btn_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: raw samples flow through two delay slots, a bit's
  // stable level follows after DB consecutive disagreeing samples, and
  // repeats are timed from the cycle a pair became "exactly one held".
  logic [5:0] m_s1, m_s2, m_stab, m_pulse;
  int         m_run [6];
  int         m_anchor [3];

  function automatic void model_step(input logic r, input logic [5:0] raw);
    logic [5:0] old_stab, s2_old;
    logic [1:0] nw, od;
    int         el;
    m_pulse = '0;
    if (!r) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0;
      for (int i = 0; i < 6; i++) m_run[i] = 0;
      for (int p = 0; p < 3; p++) m_anchor[p] = 0;
      return;
    end
    old_stab = m_stab;
    s2_old   = m_s2;
    m_s2     = m_s1;
    m_s1     = raw;
    for (int i = 0; i < 6; i++) begin
      if (s2_old[i] != old_stab[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_stab[i] = s2_old[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    for (int p = 0; p < 3; p++) begin
      nw = {m_stab[2*p+1], m_stab[2*p]};
      od = {old_stab[2*p+1], old_stab[2*p]};
      if (nw == 2'b11) continue;
      if (nw[1] && !od[1]) m_pulse[2*p+1] = 1'b1;
      if (nw[0] && !od[0]) m_pulse[2*p]   = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
      if (nw == 2'b10 || nw == 2'b01) begin
        if (od == 2'b00 || od == 2'b11 || (nw & ~od) != 2'b00) begin
          m_anchor[p] = cyc;
        end else begin
          el = cyc - m_anchor[p];
          if (el == RD || (el > RD && (el - RD) % RP == 0)) begin
            m_pulse[2*p+1] = nw[1];
            m_pulse[2*p]   = nw[0];
          end
        end
      end
`endif
    end
  endfunction

  task automatic check_value(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  task automatic check_output();
    total++;
    if ({hour_id, minute_id, seconds_id} !== m_pulse || btn_state !== m_stab) begin
      bad++;
      $display("[TB] FAIL model cyc=%0d got ids=%b state=%b want ids=%b state=%b",
               cyc, {hour_id, minute_id, seconds_id}, btn_state, m_pulse, m_stab);
    end
  endtask

  // One clock: drive, clock, advance the model, then compare away from the edge.
  task automatic apply_stimulus(input logic r, input logic [5:0] b);
    rstn = r;
    btn  = b;
    @(posedge clk);
    cyc++;
    model_step(r, b);
    #1;
    check_output();
  endtask

  task automatic do_reset();
    for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 6'h00);
  endtask

  typedef struct {
    logic       rstn;
    logic [5:0] btn;
    logic [5:0] exp_ids;
    logic [5:0] exp_state;
  } vec_t;

  vec_t       vecs [21];
  int         offs [$];
  int         exp_offs [$];
  int         found, cnt, tstart;
  logic       seen_pulse, seen_state;
  logic [5:0] rb;

  initial begin
    rstn = 1'b0;
    btn  = 6'h00;

    // Reset with all buttons held, then clean press and release of min inc.
    for (int k = 0; k < 3; k++)  vecs[k] = '{1'b0, 6'h3F, 6'h00, 6'h00};
    for (int k = 3; k < 6; k++)  vecs[k] = '{1'b1, 6'h00, 6'h00, 6'h00};
    for (int k = 6; k < 11; k++) vecs[k] = '{1'b1, 6'h08, 6'h00, 6'h00};
    vecs[11] = '{1'b1, 6'h08, 6'h08, 6'h08};
    vecs[12] = '{1'b1, 6'h08, 6'h00, 6'h08};
    vecs[13] = '{1'b1, 6'h08, 6'h00, 6'h08};
    for (int k = 14; k < 19; k++) vecs[k] = '{1'b1, 6'h00, 6'h00, 6'h08};
    vecs[19] = '{1'b1, 6'h00, 6'h00, 6'h00};
    vecs[20] = '{1'b1, 6'h00, 6'h00, 6'h00};

    for (int k = 0; k < 21; k++) begin
      apply_stimulus(vecs[k].rstn, vecs[k].btn);
      check_value($sformatf("table_ids[%0d]", k),
                  int'({hour_id, minute_id, seconds_id}), int'(vecs[k].exp_ids));
      check_value($sformatf("table_state[%0d]", k),
                  int'(btn_state), int'(vecs[k].exp_state));
    end

    // Bounce: 2 high / 1 low on sec dec never settles.
    do_reset();
    seen_pulse = 1'b0;
    seen_state = 1'b0;
    for (int k = 0; k < 40; k++) begin
      apply_stimulus(1'b1, (k < 30 && (k % 3) != 2) ? 6'h01 : 6'h00);
      if (seconds_id != 2'b00) seen_pulse = 1'b1;
      if (btn_state[0]) seen_state = 1'b1;
    end
    check_value("bounce_pulse", int'(seen_pulse), 0);
    check_value("bounce_state", int'(seen_state), 0);

    // Auto-repeat on hour inc.
    do_reset();
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      apply_stimulus(1'b1, 6'h20);
      if (hour_id[1]) found = 1;
    end
    check_value("repeat_first_press", found, 1);
    tstart = cyc;
    offs.delete();
    offs.push_back(0);
    for (int k = 1; k < 60; k++) begin
      apply_stimulus(1'b1, 6'h20);
      if (hour_id[1]) offs.push_back(cyc - tstart);
      if (hour_id[0]) check_value("repeat_no_dec", 1, 0);
    end
    exp_offs.delete();
    exp_offs.push_back(0);
`ifdef BTN_AUTOREPEAT_EN
    for (int o = RD; o < 60; o += RP) exp_offs.push_back(o);
`endif
    check_value("repeat_count", offs.size(), exp_offs.size());
    for (int k = 0; k < exp_offs.size() && k < offs.size(); k++)
      check_value($sformatf("repeat_off[%0d]", k), offs[k], exp_offs[k]);
    for (int k = 0; k < 12; k++) apply_stimulus(1'b1, 6'h00);

    // Conflict on the hour pair.
    do_reset();
    found = 0;
    cnt   = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      apply_stimulus(1'b1, 6'h10);
      if (hour_id == 2'b01) found = 1;
    end
    check_value("conflict_dec_press", found, 1);
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(1'b1, 6'h10);
      if (hour_id != 2'b00) cnt++;
    end
    for (int k = 0; k < 40; k++) begin
      apply_stimulus(1'b1, 6'h30);
      if (hour_id != 2'b00) cnt++;
    end
    check_value("conflict_held_pulses", cnt, 0);
    check_value("conflict_both_state", int'(btn_state[5:4]), 3);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      apply_stimulus(1'b1, 6'h20);
      if (hour_id != 2'b00) cnt++;
      if (!btn_state[4]) found = 1;
    end
    check_value("conflict_release_seen", found, 1);
    check_value("conflict_no_release_press", cnt, 0);
    tstart = cyc;
    offs.delete();
    for (int k = 0; k < 25; k++) begin
      apply_stimulus(1'b1, 6'h20);
      if (hour_id == 2'b10) offs.push_back(cyc - tstart);
      if (hour_id[0]) check_value("conflict_no_dec", 1, 0);
    end
`ifdef BTN_AUTOREPEAT_EN
    check_value("conflict_repeat_count", offs.size(), 1);
    if (offs.size() > 0) check_value("conflict_repeat_off", offs[0], RD);
`else
    check_value("conflict_repeat_count", offs.size(), 0);
`endif
    for (int k = 0; k < 12; k++) apply_stimulus(1'b1, 6'h00);

    // Simultaneous presses on all three inc buttons.
    do_reset();
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      apply_stimulus(1'b1, 6'h2A);
      if ({hour_id, minute_id, seconds_id} != 6'h00) found = 1;
    end
    check_value("simul_seen", found, 1);
    check_value("simul_hour", int'(hour_id), 2);
    check_value("simul_minute", int'(minute_id), 2);
    check_value("simul_seconds", int'(seconds_id), 2);

    // Reset mid-operation clears outputs on the following cycle.
    apply_stimulus(1'b0, 6'h2A);
    check_value("midreset_ids", int'({hour_id, minute_id, seconds_id}), 0);
    check_value("midreset_state", int'(btn_state), 0);

    // Randomized slowly-varying buttons with occasional resets.
    rb = 6'h00;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 11) == 0) rb[i] = ~rb[i];
      if (k % 500 < 250) rb[4] = rb[4] & ~rb[5];
      apply_stimulus(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tt_bin_clock_btn.md
# tt_bin_clock_btn

Input conditioner for the binary clock's time-set buttons. It takes six raw, bouncy, asynchronous push-button levels and produces clean single-cycle increment/decrement command pulses for the hour, minute and seconds fields. These pulses are what the binary clock core consumes on its `hour_id`/`minute_id`/`seconds_id` inputs. Per button, the block synchronizes, debounces and edge-detects the input, blocks conflicting inc+dec pairs, and optionally auto-repeats while a button is held.

## Interface
- `DEBOUNCE_CYCLES`, default 1024: cycles a synchronized input must differ from the debounced state before that state flips; ≥2.
- `REPEAT_DELAY`, default 65536: cycles from the press pulse to the first repeat pulse; ≥2.
- `REPEAT_PERIOD`, default 16384: cycles between subsequent repeat pulses; ≥2.
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset; synchronous, active-low.
- `btn_i`  in  6  raw active-high buttons: [5] hour inc, [4] hour dec, [3] min inc, [2] min dec, [1] sec inc, [0] sec dec.
- `hour_id`  out  2  [1] inc pulse, [0] dec pulse.
- `minute_id`  out  2  same encoding as `hour_id`.
- `seconds_id`  out  2  same encoding as `hour_id`.
- `btn_state_o`  out  6  debounced button levels, bit order as `btn_i`.

## Operation
- **Synchronizer:** a two-flop synchronizer per bit (s1, s2).
- **Debounce, per bit:**
  - A counter increments on each edge where s2 ≠ stable.
  - The counter clears on any edge where s2 = stable.
  - On the edge where a mismatch is seen with counter = DEBOUNCE_CYCLES−1, stable takes s2 and the counter clears.
  - `btn_state_o` = stable.
- **Press pulse:** a rising edge of stable produces a registered one-cycle pulse on the matching id bit. A falling edge never pulses.
- **Pair conflict:** while both stable bits of a pair are 1, that pair emits no pulses (neither press nor repeat).
  - Pressing the second button while the first is held produces no pulse.
  - When one of the two is released, the remaining held button emits no press pulse. It restarts its repeat timer from 0, counting as if it had just pulsed.
- **Auto-repeat:** one repeat counter per pair.
  - The counter is cleared by a press pulse; it then counts while exactly one button of the pair is stably held.
  - A pulse is emitted when the count reaches REPEAT_DELAY, then every REPEAT_PERIOD after that.
  - Counter width is $clog2 of the largest count plus 1. The counter never wraps; it reloads to the delay-elapsed phase after each repeat pulse.
- **Pair independence:** the three pairs are independent; simultaneous pulses on different pairs are allowed.
- **Mutual exclusion:** inc and dec of the same pair are never high in the same cycle.

## Timing
- **Reset values:** all outputs 0. Synchronizers, stable levels, debounce counters and repeat counters are all 0.
- **Press latency:** raw 0→1 sampled at edge N gives stable = 1 after edge N+DEBOUNCE_CYCLES+1. The id pulse is high for exactly the one cycle after that same edge.
- **Bounce rejection:** a glitch shorter than DEBOUNCE_CYCLES cycles (as seen at s2) causes no change in stable and no pulse.
- **Release latency:** stable falls after the same latency as a press. The repeat counter clears on that edge. If a repeat would fall due on that edge, release wins and no pulse is emitted.
- **Held through reset:** a button held during reset is seen as a new press after reset deasserts, with a pulse at the normal latency.
- **Reset mid-operation:** asserting `rstn_i` low for one edge clears all state. Outputs are 0 in the following cycle, and pending pulses are discarded.

## Configuration
- **`BTN_AUTOREPEAT_EN` defined:** auto-repeat logic exists exactly as described above.
- **`BTN_AUTOREPEAT_EN` undefined:** repeat counters are not instantiated.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.
  - Only press pulses are produced.
  - Pair-conflict suppression still applies: releasing one of two held buttons produces nothing.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- **Reset:** hold `rstn_i`=0 for 3 cycles with `btn_i`=6'h3F → all outputs 0; release with `btn_i`=0 → outputs stay 0.
- **Clean press:** `btn_i[3]`=1 from edge 10 → `minute_id`=2'b10 only in the cycle after edge 15; `btn_state_o[3]`=1 from then on; no pulse on release.
- **Bounce:** `btn_i[0]` toggles with a 2-cycle high / 1-cycle low pattern for 30 cycles, then goes 0 → no pulse on `seconds_id`, and `btn_state_o[0]` stays 0.
- **Auto-repeat (macro on):** hold `btn_i[5]` for 60 cycles after its press pulse at cycle P → `hour_id[1]` pulses at P, P+20, P+28, P+36, P+44, P+52. With the macro off → a single pulse at P.
- **Conflict:** press `btn_i[4]`, then press `btn_i[5]` 10 cycles later, hold both 40 cycles, then release `btn_i[4]` → only the initial dec pulse; no pulses while both are held; no press pulse after the release; the hour inc repeat arrives 20 cycles after the release takes effect.
- **Simultaneous pairs:** `btn_i[5]`, `btn_i[3]` and `btn_i[1]` rise on the same edge → `hour_id`, `minute_id` and `seconds_id` all equal 2'b10 in the same cycle.
